// File: rtl/xu_cmp_issue_arb.sv
// Round-robin issue arbiter sharing the XU compare/trap datapath among THREADS requesters.
// Tracks each granted op through ex1..ex3 with its thread tag, applying per-thread flush and in-flight limits.
module xu_cmp_issue_arb #(
    parameter int unsigned THREADS  = 2,
    parameter int unsigned MAX_INFL = 2
) (
    input  logic                   nclk,
    input  logic                   rst_b,
    input  logic [THREADS-1:0]     req_val,
    input  logic [2*THREADS-1:0]   req_type,
    input  logic [THREADS-1:0]     req_64b,
    input  logic [5*THREADS-1:0]   req_instr,
    output logic [THREADS-1:0]     req_rdy,
    input  logic [THREADS-1:0]     flush,
    output logic                   ex1_msb_64b_sel,
    output logic                   ex2_act,
    output logic [4:0]             ex2_instr,
    output logic                   ex2_sel_trap,
    output logic                   ex2_sel_cmpl,
    output logic                   ex2_sel_cmp,
    input  logic [2:0]             ex3_alu_cr,
    input  logic                   ex3_trap_val,
    output logic [THREADS-1:0]     res_val,
    output logic [2:0]             res_cr,
    output logic                   res_trap
);

    localparam int unsigned TW = (THREADS > 2) ? 2 : 1;
    localparam int unsigned CW = 2;

    localparam logic [1:0] TYPE_CMP  = 2'b00;
    localparam logic [1:0] TYPE_CMPL = 2'b01;
    localparam logic [1:0] TYPE_TRAP = 2'b10;
    localparam logic [1:0] TYPE_RSVD = 2'b11;

    logic [TW-1:0]    r_ptr;
    logic [CW-1:0]    r_infl [THREADS];

    logic             r_ex1_v;
    logic [TW-1:0]    r_ex1_tid;
    logic [1:0]       r_ex1_type;
    logic [4:0]       r_ex1_instr;
    logic             r_ex1_msb;

    logic             r_ex2_v;
    logic [TW-1:0]    r_ex2_tid;
    logic             r_ex2_sel_cmp;
    logic             r_ex2_sel_cmpl;
    logic             r_ex2_sel_trap;
    logic [4:0]       r_ex2_instr;

    logic             r_ex3_v;
    logic [TW-1:0]    r_ex3_tid;
    logic             r_ex3_trap;

    logic [THREADS-1:0] w_elig;
    logic [THREADS-1:0] w_gnt;
    logic [THREADS-1:0] w_ret;
    logic               w_gnt_v;
    logic [TW-1:0]      w_gnt_tid;
    logic [1:0]         w_gnt_type;
    logic               w_ex1_live;
    logic               w_ex2_live;

    // Eligibility and round-robin search starting at the pointer, with wrap
    always_comb begin
        w_elig    = '0;
        w_gnt     = '0;
        w_gnt_v   = 1'b0;
        w_gnt_tid = '0;
        for (int unsigned t = 0; t < THREADS; t++) begin
            w_elig[t] = req_val[t] && (req_type[2*t +: 2] != TYPE_RSVD) && !flush[t]
                        && (r_infl[t] < CW'(MAX_INFL));
        end
        for (int unsigned i = 0; i < THREADS; i++) begin
            if (!w_gnt_v && w_elig[(32'(r_ptr) + i) % THREADS]) begin
                w_gnt_v   = 1'b1;
                w_gnt_tid = TW'((32'(r_ptr) + i) % THREADS);
            end
        end
        if (w_gnt_v) begin
            w_gnt[w_gnt_tid] = 1'b1;
        end
        w_gnt_type = req_type[2*w_gnt_tid +: 2];
    end

    // Ex3 retire and flush-qualified pipeline advance
    always_comb begin
        w_ret = '0;
        for (int unsigned t = 0; t < THREADS; t++) begin
            w_ret[t] = r_ex3_v && (r_ex3_tid == TW'(t));
        end
        w_ex1_live = r_ex1_v && !flush[r_ex1_tid];
        w_ex2_live = r_ex2_v && !flush[r_ex2_tid];
    end

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            r_ptr          <= '0;
            r_ex1_v        <= 1'b0;
            r_ex1_tid      <= '0;
            r_ex1_type     <= '0;
            r_ex1_instr    <= '0;
            r_ex1_msb      <= 1'b0;
            r_ex2_v        <= 1'b0;
            r_ex2_tid      <= '0;
            r_ex2_sel_cmp  <= 1'b0;
            r_ex2_sel_cmpl <= 1'b0;
            r_ex2_sel_trap <= 1'b0;
            r_ex2_instr    <= '0;
            r_ex3_v        <= 1'b0;
            r_ex3_tid      <= '0;
            r_ex3_trap     <= 1'b0;
            for (int unsigned t = 0; t < THREADS; t++) begin
                r_infl[t] <= '0;
            end
        end else begin
            if (w_gnt_v) begin
                r_ptr <= TW'((32'(w_gnt_tid) + 1) % THREADS);
            end

            r_ex1_v     <= w_gnt_v;
            r_ex1_tid   <= w_gnt_tid;
            r_ex1_type  <= w_gnt_type;
            r_ex1_instr <= req_instr[5*w_gnt_tid +: 5];
            r_ex1_msb   <= w_gnt_v && req_64b[w_gnt_tid];

            r_ex2_v        <= w_ex1_live;
            r_ex2_tid      <= r_ex1_tid;
            r_ex2_sel_cmp  <= w_ex1_live && (r_ex1_type == TYPE_CMP);
            r_ex2_sel_cmpl <= w_ex1_live && (r_ex1_type == TYPE_CMPL);
            r_ex2_sel_trap <= w_ex1_live && (r_ex1_type == TYPE_TRAP);
            r_ex2_instr    <= (w_ex1_live && (r_ex1_type == TYPE_TRAP)) ? r_ex1_instr : 5'b0;

            r_ex3_v    <= w_ex2_live;
            r_ex3_tid  <= r_ex2_tid;
            r_ex3_trap <= w_ex2_live && r_ex2_sel_trap;

            // Flush wipes the whole count since all of the thread's ops die at this edge
            for (int unsigned t = 0; t < THREADS; t++) begin
                if (flush[t]) begin
                    r_infl[t] <= '0;
                end else begin
                    r_infl[t] <= r_infl[t] + CW'(w_gnt[t]) - CW'(w_ret[t]);
                end
            end
        end
    end

    assign req_rdy         = w_gnt;
    assign ex1_msb_64b_sel = r_ex1_msb;
    assign ex2_act         = r_ex2_v;
    assign ex2_instr       = r_ex2_instr;
    assign ex2_sel_trap    = r_ex2_sel_trap;
    assign ex2_sel_cmpl    = r_ex2_sel_cmpl;
    assign ex2_sel_cmp     = r_ex2_sel_cmp;

    // A flush arriving while the op sits in ex3 kills its result in the same cycle
    assign res_val  = w_ret & ~flush;
    assign res_cr   = (|res_val) ? ex3_alu_cr : 3'b0;
    assign res_trap = ex3_trap_val && r_ex3_trap && (|res_val);

endmodule
